// File: rtl/conv_transpose1d_upsample.sv
//==============================================================================
// conv_transpose1d_upsample: 2-channel transposed 1-D conv (kernel 4, stride 2)
// Optional macro RESIDUAL_EN adds a repeat-upsampled skip input.  Rev 1.0
//==============================================================================
`default_nettype none

module conv_transpose1d_upsample #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data_0,
  input  logic signed [DATA_WIDTH-1:0] in_data_1,
`ifdef RESIDUAL_EN
  input  logic signed [DATA_WIDTH-1:0] skip_data_0,
  input  logic signed [DATA_WIDTH-1:0] skip_data_1,
`endif
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] output_data_0,
  output logic signed [DATA_WIDTH-1:0] output_data_1,
  input  logic                         w_we,
  input  logic [3:0]                   w_addr,
  input  logic signed [DATA_WIDTH-1:0] w_data
);

  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int ACC_W  = PROD_W + 2;
  localparam logic signed [DATA_WIDTH-1:0] ONE     = DATA_WIDTH'(1 << FRAC_BITS);
  localparam logic signed [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } state_t;

  state_t state, next_state;

  // Weight index is {tap, out_ch, in_ch}
  logic signed [DATA_WIDTH-1:0] weights [16];
  logic signed [DATA_WIDTH-1:0] x_prev_0, x_prev_1;
  logic signed [DATA_WIDTH-1:0] hist_0, hist_1;
  logic signed [DATA_WIDTH-1:0] odd_hold_0, odd_hold_1;
  logic signed [ACC_W-1:0]      acc_e0, acc_e1, acc_o0, acc_o1;
  logic signed [DATA_WIDTH-1:0] even_0, even_1, odd_0, odd_1;
  logic                         accept;

  function automatic logic signed [ACC_W-1:0] mac4(
    input logic signed [DATA_WIDTH-1:0] wa, wb, wc, wd,
    input logic signed [DATA_WIDTH-1:0] xa, xb, pa, pb
  );
    logic signed [PROD_W-1:0] pr0, pr1, pr2, pr3;
    logic signed [ACC_W-1:0]  acc;
    pr0 = PROD_W'(wa) * PROD_W'(xa);
    pr1 = PROD_W'(wb) * PROD_W'(xb);
    pr2 = PROD_W'(wc) * PROD_W'(pa);
    pr3 = PROD_W'(wd) * PROD_W'(pb);
    acc = ACC_W'(pr0) + ACC_W'(pr1) + ACC_W'(pr2) + ACC_W'(pr3);
    return acc >>> FRAC_BITS;
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [ACC_W-1:0] v);
    if (v > ACC_W'(OUT_MAX))      return OUT_MAX;
    else if (v < ACC_W'(OUT_MIN)) return OUT_MIN;
    else                          return v[DATA_WIDTH-1:0];
  endfunction

  // A clear coinciding with an accept must already see an empty history
  always_comb begin
    hist_0 = clear ? '0 : x_prev_0;
    hist_1 = clear ? '0 : x_prev_1;
    acc_e0 = mac4(weights[0],  weights[1],  weights[8],  weights[9],
                  in_data_0, in_data_1, hist_0, hist_1);
    acc_e1 = mac4(weights[2],  weights[3],  weights[10], weights[11],
                  in_data_0, in_data_1, hist_0, hist_1);
    acc_o0 = mac4(weights[4],  weights[5],  weights[12], weights[13],
                  in_data_0, in_data_1, hist_0, hist_1);
    acc_o1 = mac4(weights[6],  weights[7],  weights[14], weights[15],
                  in_data_0, in_data_1, hist_0, hist_1);
`ifdef RESIDUAL_EN
    acc_e0 = acc_e0 + ACC_W'(skip_data_0);
    acc_e1 = acc_e1 + ACC_W'(skip_data_1);
    acc_o0 = acc_o0 + ACC_W'(skip_data_0);
    acc_o1 = acc_o1 + ACC_W'(skip_data_1);
`endif
    even_0 = sat(acc_e0);
    even_1 = sat(acc_e1);
    odd_0  = sat(acc_o0);
    odd_1  = sat(acc_o1);
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = EVEN;
      end
      EVEN: begin
        out_valid = 1'b1;
        if (out_ready) next_state = ODD;
      end
      ODD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) next_state = in_valid ? EVEN : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Writes land at the edge, so an accept in the same cycle sees old weights
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++)
        weights[i] <= (i == 0 || i == 3 || i == 4 || i == 7) ? ONE : '0;
    end else if (w_we) begin
      weights[w_addr] <= w_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_prev_0 <= '0;
      x_prev_1 <= '0;
    end else if (accept) begin
      x_prev_0 <= in_data_0;
      x_prev_1 <= in_data_1;
    end else if (clear) begin
      x_prev_0 <= '0;
      x_prev_1 <= '0;
    end
  end

  // Both phases are registered at accept; the odd pair waits in odd_hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      output_data_0 <= '0;
      output_data_1 <= '0;
      odd_hold_0    <= '0;
      odd_hold_1    <= '0;
    end else if (accept) begin
      output_data_0 <= even_0;
      output_data_1 <= even_1;
      odd_hold_0    <= odd_0;
      odd_hold_1    <= odd_1;
    end else if (state == EVEN && out_ready) begin
      output_data_0 <= odd_hold_0;
      output_data_1 <= odd_hold_1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_conv_transpose1d_upsample.sv
//==============================================================================
// tb_conv_transpose1d_upsample: directed + random bench with reference model
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_conv_transpose1d_upsample;

  logic               clk = 1'b0;
  logic               rst;
  logic               clear;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_data_0, in_data_1;
  logic signed [15:0] skip_data_0, skip_data_1;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] output_data_0, output_data_1;
  logic               w_we;
  logic [3:0]         w_addr;
  logic signed [15:0] w_data;

  logic hold_ready, rand_mode, rand_ready;
  assign out_ready = rand_mode ? rand_ready : hold_ready;

  conv_transpose1d_upsample #(.DATA_WIDTH(16), .FRAC_BITS(8)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data_0(in_data_0), .in_data_1(in_data_1),
`ifdef RESIDUAL_EN
    .skip_data_0(skip_data_0), .skip_data_1(skip_data_1),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .output_data_0(output_data_0), .output_data_1(output_data_1),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data)
  );

  always #5 clk = ~clk;

  typedef struct { int d0; int d1; } pair_t;
  typedef struct { int d0; int d1; int cyc; } cap_t;

  int    n_assert = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    wm [16];
  int    prev0, prev1;
  pair_t exp_q [$];
  cap_t  cap [$];

  task automatic check(input string tag, input int obs, input int expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) wm[i] = 0;
    wm[0] = 256; wm[3] = 256; wm[4] = 256; wm[7] = 256;
    prev0 = 0; prev1 = 0;
  endfunction

  // y = floor((Wcur*x + Wprev*p) / 2^8) + skip, clamped to int16
  function automatic int model_y(int tc, int tp, int oc, int x0, int x1, int p0, int p1, int sk);
    longint acc;
    acc = longint'(wm[tc*4+oc*2])   * x0 + longint'(wm[tc*4+oc*2+1]) * x1
        + longint'(wm[tp*4+oc*2])   * p0 + longint'(wm[tp*4+oc*2+1]) * p1;
    acc = acc >>> 8;
`ifdef RESIDUAL_EN
    acc = acc + sk;
`endif
    if (acc > 32767)  acc = 32767;
    if (acc < -32768) acc = -32768;
    return int'(acc);
  endfunction

  always @(posedge clk) begin
    cyc++;
    #1 rand_ready = ($urandom_range(0, 3) != 0);
  end

  // Every output transfer is checked against the model and captured
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        check("out_data_0", int'(output_data_0), exp_q[0].d0);
        check("out_data_1", int'(output_data_1), exp_q[0].d1);
        void'(exp_q.pop_front());
      end
      cap.push_back('{int'(output_data_0), int'(output_data_1), cyc});
    end
  end

  // Entered and left at posedge+1
  task automatic send(input int x0, input int x1, input int s0 = 0, input int s1 = 0,
                      input bit do_clear = 0, input bit do_we = 0,
                      input int wa = 0, input int wd = 0);
    bit done = 0;
    int tries = 0;
    in_valid = 1; in_data_0 = 16'(x0); in_data_1 = 16'(x1);
    skip_data_0 = 16'(s0); skip_data_1 = 16'(s1);
    clear = do_clear; w_we = do_we; w_addr = 4'(wa); w_data = 16'(wd);
    while (!done && tries < 100) begin
      @(negedge clk);
      if (do_clear) begin prev0 = 0; prev1 = 0; end
      if (in_ready) begin
        exp_q.push_back('{model_y(0, 2, 0, x0, x1, prev0, prev1, s0),
                          model_y(0, 2, 1, x0, x1, prev0, prev1, s1)});
        exp_q.push_back('{model_y(1, 3, 0, x0, x1, prev0, prev1, s0),
                          model_y(1, 3, 1, x0, x1, prev0, prev1, s1)});
        prev0 = x0; prev1 = x1;
        done = 1;
      end
      if (do_we) wm[wa] = int'(16'(wd) ^ 16'h0) - ((wd & 32'h8000) != 0 ? 65536 : 0);
      @(posedge clk); #1;
      tries++;
    end
    in_valid = 0; clear = 0; w_we = 0;
    check("accept_timeout", int'(done), 1);
  endtask

  task automatic wr(input int a, input int d);
    w_we = 1; w_addr = 4'(a); w_data = 16'(d);
    @(posedge clk); #1;
    w_we = 0;
    wm[a] = ((d & 32'h8000) != 0) ? ((d & 32'hFFFF) - 65536) : (d & 32'hFFFF);
  endtask

  task automatic clr();
    clear = 1;
    @(posedge clk); #1;
    clear = 0;
    prev0 = 0; prev1 = 0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  int b;

  initial begin
    rst = 0; clear = 0; in_valid = 0; w_we = 0; w_addr = 0; w_data = 0;
    in_data_0 = 0; in_data_1 = 0; skip_data_0 = 0; skip_data_1 = 0;
    hold_ready = 1; rand_mode = 0; rand_ready = 1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data_0", int'(output_data_0), 0);
    check("rst_in_ready", int'(in_ready), 1);
    rst = 1;
    @(posedge clk); #1;

    // Nearest-neighbour upsampling, back-to-back with no bubble
    b = cap.size();
    send(256, 1280);
    send(512, 1536);
    drain();
    check("nn_y0_0", cap[b].d0, 256);   check("nn_y0_1", cap[b].d1, 1280);
    check("nn_y1_0", cap[b+1].d0, 256); check("nn_y1_1", cap[b+1].d1, 1280);
    check("nn_y2_0", cap[b+2].d0, 512); check("nn_y2_1", cap[b+2].d1, 1536);
    check("nn_y3_0", cap[b+3].d0, 512); check("nn_y3_1", cap[b+3].d1, 1536);
    for (int k = 1; k < 4; k++) check("nn_no_bubble", cap[b+k].cyc - cap[b].cyc, k);

    // Tap 2 identity mixes in the previous sample on even outputs
    wr(8, 256); wr(11, 256);
    clr();
    b = cap.size();
    send(256, 0);
    send(512, 0);
    drain();
    check("t2_even0", cap[b].d0, 256);
    check("t2_odd0", cap[b+1].d0, 256);
    check("t2_even1", cap[b+2].d0, 768);
    check("t2_odd1", cap[b+3].d0, 512);
    check("t2_ch1", cap[b+2].d1, 0);

    // Saturation at both rails
    wr(0, 16'h7FFF); clr();
    b = cap.size();
    send(32767, 0);
    drain();
    check("sat_pos", cap[b].d0, 32767);
    wr(0, 16'h8000); clr();
    b = cap.size();
    send(32767, 0);
    drain();
    check("sat_neg", cap[b].d0, -32768);
    wr(0, 256);

    // Backpressure: output held stable, input blocked
    hold_ready = 0;
    clr();
    b = cap.size();
    send(256, 0);
    repeat (5) begin
      @(negedge clk);
      check("hold_valid", int'(out_valid), 1);
      check("hold_in_ready", int'(in_ready), 0);
      check("hold_data", int'(output_data_0), 256);
    end
    @(posedge clk); #1;
    hold_ready = 1;
    drain();
    check("hold_count", cap.size() - b, 2);
    check("hold_even", cap[b].d0, 256);
    check("hold_odd", cap[b+1].d0, 256);

    // clear between inputs, clear with accept, write with accept
    clr();
    b = cap.size();
    send(256, 256);
    drain();
    clr();
    send(256, 256);
    drain();
    check("clr_even_0", cap[b+2].d0, 256);
    check("clr_even_1", cap[b+2].d1, 256);
    b = cap.size();
    send(256, 0, 0, 0, 1, 1, 0, 512);
    drain();
    check("clr_acc_oldw", cap[b].d0, 256);
    b = cap.size();
    send(256, 0, 0, 0, 1);
    drain();
    check("newweight", cap[b].d0, 512);
    wr(0, 256);

    // Mid-operation reset aborts the pair and restores reset weights
    hold_ready = 0;
    send(100, 200);
    rst = 0;
    #1;
    exp_q.delete();
    model_reset();
    check("mrst_valid", int'(out_valid), 0);
    check("mrst_data", int'(output_data_0), 0);
    @(posedge clk); #1;
    rst = 1;
    hold_ready = 1;
    @(posedge clk); #1;
    b = cap.size();
    send(300, -400);
    drain();
    check("mrst_w_0", cap[b].d0, 300);
    check("mrst_w_1", cap[b+1].d1, -400);

`ifdef RESIDUAL_EN
    b = cap.size();
    clr();
    send(256, 1280, 256, 1280);
    drain();
    check("res_even_0", cap[b].d0, 512);  check("res_even_1", cap[b].d1, 2560);
    check("res_odd_0", cap[b+1].d0, 512); check("res_odd_1", cap[b+1].d1, 2560);
`endif

    // Random traffic with random backpressure, weights and clears
    rand_mode = 1;
    for (int i = 0; i < 16; i++) wr(i, int'($urandom_range(0, 65535)));
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) == 0) wr(int'($urandom_range(0, 15)), int'($urandom_range(0, 65535)));
      send(int'($signed(16'($urandom))), int'($signed(16'($urandom))),
           int'($signed(16'($urandom))), int'($signed(16'($urandom))),
           ($urandom_range(0, 7) == 0));
    end
    rand_mode = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
